// File: rtl/vga_pkg.sv
// Shared VGA timing types and reference constants used by the sync driver,
// the sync monitor and their benches.
package vga_pkg;

  // Monitor lock state.
  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } mon_state_t;

  // XGA (1024x768 @ 60 Hz) line and frame timing.
  localparam int H_TOTAL = 1344;
  localparam int H_SYNC  = 136;
  localparam int V_TOTAL = 806;
  localparam int V_SYNC  = 6;

endpackage

// File: rtl/vga_edge_detect.sv
// Registers one active-low sync line and reports its edges. The edges are
// combinational against the live input, so they are visible in the same
// cycle the input changes.
module vga_edge_detect (
  input  logic clk_vga,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic din_r;

  // Previous-cycle copy of the line; idles high (sync inactive) out of reset.
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) din_r <= 1'b1;
    else        din_r <= din;
  end

  assign fall = din_r & ~din;
  assign rise = ~din_r & din;

endmodule

// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing monitor. Measures line period, hsync width, lines
// per frame and vsync width from an hs/vs pair, locks once the measurements
// repeat for LOCK_FRAMES frames, and flags loss of lock or sync.
module vga_sync_monitor
  import vga_pkg::*;
#(
  parameter int H_W         = 12,
  parameter int V_W         = 11,
  parameter int LOCK_FRAMES = 2,
  parameter int TIMEOUT     = 4095,
  parameter int V_MAX       = 2047
) (
  input  logic           clk_vga,
  input  logic           rst_n,
  input  logic           hs,
  input  logic           vs,
  output logic [H_W-1:0] h_total,
  output logic [H_W-1:0] h_sync,
  output logic [V_W-1:0] v_total,
  output logic [V_W-1:0] v_sync,
  output logic [H_W-1:0] h_pos,
  output logic [V_W-1:0] v_pos,
  output logic           frame_start,
  output logic           locked,
  output logic           mode_err
);

  localparam logic [H_W-1:0] H_SAT = '1;
  localparam logic [V_W-1:0] V_SAT = '1;
  localparam logic [H_W-1:0] H_TO  = H_W'(TIMEOUT);
  localparam logic [V_W-1:0] V_TO  = V_W'(V_MAX);
  localparam int             MW    = (LOCK_FRAMES > 1) ? $clog2(LOCK_FRAMES) : 1;
  localparam logic [MW-1:0]  LOCK_AT = MW'(LOCK_FRAMES - 1);
  localparam int             SW    = 2*H_W + 2*V_W;

  logic           hs_rise, hs_fall, vs_rise, vs_fall;
  logic [H_W-1:0] h_cnt, line_len, hsw;
  logic [V_W-1:0] v_cnt, vsw;
  logic           have_prev, line_err;
  logic           len_mismatch, line_err_now;
  logic           timeout;
  logic [H_W-1:0] len_nxt, hsw_nxt;
  logic [SW-1:0]  snap_nxt, ref_q;
  logic           ref_valid, snap_ok;
  logic [MW-1:0]  match_cnt, match_nxt;
  mon_state_t     state;

  vga_edge_detect u_hs_edge (
    .clk_vga (clk_vga),
    .rst_n   (rst_n),
    .din     (hs),
    .rise    (hs_rise),
    .fall    (hs_fall)
  );

  vga_edge_detect u_vs_edge (
    .clk_vga (clk_vga),
    .rst_n   (rst_n),
    .din     (vs),
    .rise    (vs_rise),
    .fall    (vs_fall)
  );

  // Clock counter within a line: line period at hs fall, low width at hs rise.
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt    <= '0;
      line_len <= '0;
      hsw      <= '0;
    end else begin
      if (hs_fall) begin
        line_len <= h_cnt;
        h_cnt    <= H_W'(1);
      end else if (h_cnt != H_SAT) begin
        h_cnt <= h_cnt + 1'b1;
      end
      if (hs_rise) hsw <= h_cnt;
    end
  end

  // A line only counts as irregular against an earlier line of the same frame,
  // so the line that ends first after a vs fall is never compared.
  assign len_mismatch = hs_fall & have_prev & (h_cnt != line_len);
  // The last line of a frame ends on the closing vs fall; fold it in here.
  assign line_err_now = line_err | len_mismatch;

  // Sticky per-frame line-length consistency flag.
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      have_prev <= 1'b0;
      line_err  <= 1'b0;
    end else if (vs_fall) begin
      have_prev <= 1'b0;
      line_err  <= 1'b0;
    end else if (hs_fall) begin
      have_prev <= 1'b1;
      if (len_mismatch) line_err <= 1'b1;
    end
  end

  // Line counter within a frame; a line starting on the vs fall is line 1.
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      v_cnt <= '0;
      vsw   <= '0;
    end else begin
      if (vs_fall)                       v_cnt <= hs_fall ? V_W'(1) : '0;
      else if (hs_fall && v_cnt != V_SAT) v_cnt <= v_cnt + 1'b1;
      // A line starting on the vs rise still belongs to the sync pulse.
      if (vs_rise) vsw <= v_cnt + V_W'(hs_fall);
    end
  end

  // Frame measurement as seen at the closing vs fall, including any edge
  // that lands in that same cycle.
  assign len_nxt  = hs_fall ? h_cnt : line_len;
  assign hsw_nxt  = hs_rise ? h_cnt : hsw;
  assign snap_nxt = {len_nxt, hsw_nxt, v_cnt, vsw};
  assign snap_ok  = ref_valid & (snap_nxt == ref_q) & ~line_err_now;
  assign match_nxt = snap_ok ? match_cnt + 1'b1 : '0;

  // Sync stays lost while either counter sits at its limit.
  assign timeout = (h_cnt == H_TO) | (v_cnt == V_TO);

  // Lock FSM with snapshot registers and registered status pulses.
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SEARCH;
      locked      <= 1'b0;
      mode_err    <= 1'b0;
      frame_start <= 1'b0;
      match_cnt   <= '0;
      ref_valid   <= 1'b0;
      ref_q       <= '0;
      h_total     <= '0;
      h_sync      <= '0;
      v_total     <= '0;
      v_sync      <= '0;
    end else begin
      mode_err    <= 1'b0;
      frame_start <= vs_fall;
      if (timeout) begin
        // Snapshot outputs hold their last good values.
        if (state == LOCKED) mode_err <= 1'b1;
        state     <= SEARCH;
        locked    <= 1'b0;
        match_cnt <= '0;
        ref_valid <= 1'b0;
      end else if (vs_fall) begin
        unique case (state)
          SEARCH: begin
            // Partial frame seen so far is meaningless; start measuring.
            state     <= MEASURE;
            match_cnt <= '0;
            ref_valid <= 1'b0;
          end
          MEASURE: begin
            {h_total, h_sync, v_total, v_sync} <= snap_nxt;
            ref_q     <= snap_nxt;
            ref_valid <= 1'b1;
            match_cnt <= match_nxt;
            if (match_nxt == LOCK_AT) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end
          end
          LOCKED: begin
            {h_total, h_sync, v_total, v_sync} <= snap_nxt;
            if (!snap_ok) begin
              mode_err  <= 1'b1;
              locked    <= 1'b0;
              match_cnt <= '0;
              state     <= MEASURE;
              ref_q     <= snap_nxt;
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

  assign h_pos = h_cnt;
  assign v_pos = v_cnt;

endmodule
